// File: rtl/processor_pkg.sv
// Shared processor constants: multiplier state encodings and default datapath width.
package processor_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    localparam logic [1:0] MULT_IDLE = 2'd0;
    localparam logic [1:0] MULT_CALC = 2'd1;
    localparam logic [1:0] MULT_FIX  = 2'd2;

endpackage

// File: rtl/mult_negate.sv
// Conditional two's-complement: result = neg ? -value : value.
module mult_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_unit.sv
// Multicycle radix-2 shift-add multiplier with HI/LO result registers and a
// stall request for MFHI/MFLO issued while a multiply is in flight.
module mult_unit
    import processor_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             mult_stall
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    product;
    logic [WIDTH:0]   sum;

    mult_negate #(.WIDTH(WIDTH)) u_neg_a (
        .neg    (mult_sign & op_a[WIDTH-1]),
        .value  (op_a),
        .result (a_mag)
    );

    mult_negate #(.WIDTH(WIDTH)) u_neg_b (
        .neg    (mult_sign & op_b[WIDTH-1]),
        .value  (op_b),
        .result (b_mag)
    );

    mult_negate #(.WIDTH(PW)) u_neg_res (
        .neg    (neg_q),
        .value  (acc_q),
        .result (product)
    );

    // Upper accumulator half plus optional multiplicand, carry kept in the MSB
    assign sum = {1'b0, acc_q[PW-1:WIDTH]}
               + {1'b0, (mplier_q[0] ? mcand_q : WIDTH'(0))};

    assign mult_stall = busy & hilo_read;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi;
        lo_d     = lo;
        busy_d   = busy;
        done_d   = 1'b0;

        case (state_q)
            MULT_IDLE: begin
                if (start_mult) begin
                    neg_d    = mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = MULT_CALC;
                end
            end
            MULT_CALC: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MULT_FIX;
                end
            end
            MULT_FIX: begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = MULT_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = MULT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MULT_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi       <= hi_d;
            lo       <= lo_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
